// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm arm/disarm controller.
// Holds the FSM state enum, the keypad code width and the delay timer width.
package alarm_pkg;

    localparam int CODE_W  = 6;
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_EXIT,
        ST_ARMED,
        ST_ENTRY,
        ST_ALARM
    } state_t;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter with a zero flag; it holds at zero until reloaded.
// Ports: clk, rst_n, load (load strobe), load_val (value to load), zero (count==0).
module alarm_timer
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_arm_controller.sv
// Alarm arm/disarm FSM: DISARMED, EXIT, ARMED, ENTRY, ALARM with keypad code control.
// Ports: clk, rst_n, code, code_valid, motion1, motion2, reed -> armed, entry_pending,
// alarm, lockout. Define ALARM_LOCKOUT_EN to add the wrong-code keypad lockout.
module alarm_arm_controller
    import alarm_pkg::*;
#(
    parameter logic [CODE_W-1:0] ARM_CODE   = 6'b001111,
    parameter int                EXIT_DLY   = 16,
    parameter int                ENTRY_DLY  = 16,
    parameter int                SIREN_TIME = 64,
    parameter int                MAX_TRIES  = 3,
    parameter int                LOCK_TIME  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              motion1,
    input  logic              motion2,
    input  logic              reed,
    output logic              armed,
    output logic              entry_pending,
    output logic              alarm,
    output logic              lockout
);

    // Timers hold delay-1 so a timed state lasts exactly its delay.
    localparam logic [TIMER_W-1:0] EXIT_LD  = TIMER_W'(EXIT_DLY - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LD = TIMER_W'(ENTRY_DLY - 1);
    localparam logic [TIMER_W-1:0] SIREN_LD = TIMER_W'(SIREN_TIME - 1);

    state_t             state;
    state_t             next;
    logic               code_ok;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_zero;
    logic               motion;

    assign motion  = motion1 | motion2;
    assign code_ok = code_valid && (code == ARM_CODE) && !lockout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DISARMED;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next   = state;
        t_load = 1'b0;
        t_val  = '0;
        unique case (state)
            ST_DISARMED: begin
                if (code_ok) begin
                    next   = ST_EXIT;
                    t_load = 1'b1;
                    t_val  = EXIT_LD;
                end
            end
            ST_EXIT: begin
                if (code_ok) begin
                    next   = ST_DISARMED;
                    t_load = 1'b1;
                end else if (t_zero) begin
                    next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (code_ok) begin
                    next = ST_DISARMED;
                end else if (motion) begin
                    next   = ST_ALARM;
                    t_load = 1'b1;
                    t_val  = SIREN_LD;
                end else if (reed) begin
                    next   = ST_ENTRY;
                    t_load = 1'b1;
                    t_val  = ENTRY_LD;
                end
            end
            ST_ENTRY: begin
                if (code_ok) begin
                    next   = ST_DISARMED;
                    t_load = 1'b1;
                end else if (t_zero) begin
                    next   = ST_ALARM;
                    t_load = 1'b1;
                    t_val  = SIREN_LD;
                end
            end
            ST_ALARM: begin
                if (code_ok) begin
                    next   = ST_DISARMED;
                    t_load = 1'b1;
                end else if (t_zero) begin
                    next = ST_ARMED;
                end
            end
            default: begin
                next = ST_DISARMED;
            end
        endcase
    end

    alarm_timer u_state_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    assign armed = (state == ST_ARMED) || (state == ST_ENTRY) ||
                   (state == ST_ALARM);
    assign entry_pending = (state == ST_ENTRY);
    assign alarm         = (state == ST_ALARM);

`ifdef ALARM_LOCKOUT_EN
    localparam int                 FW      = $clog2(MAX_TRIES + 1);
    localparam logic [TIMER_W-1:0] LOCK_LD = TIMER_W'(LOCK_TIME - 1);

    logic [FW-1:0] fails;
    logic          lock_q;
    logic          lock_zero;
    logic          lock_load;
    logic          wrong;

    // Strobes seen while locked neither count nor clear.
    assign wrong     = code_valid && !lock_q && (code != ARM_CODE);
    assign lock_load = wrong && (fails == FW'(MAX_TRIES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fails  <= '0;
            lock_q <= 1'b0;
        end else begin
            if (code_ok || lock_load) begin
                fails <= '0;
            end else if (wrong) begin
                fails <= fails + 1'b1;
            end
            if (lock_load) begin
                lock_q <= 1'b1;
            end else if (lock_q && lock_zero) begin
                lock_q <= 1'b0;
            end
        end
    end

    alarm_timer u_lock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (LOCK_LD),
        .zero     (lock_zero)
    );

    assign lockout = lock_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(MAX_TRIES), 32'(LOCK_TIME)};
    assign lockout    = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Self-checking bench for alarm_arm_controller: vector table, corner sequences,
// and random stimulus against a remaining-cycles reference model.
module tb_alarm_arm_controller;

    localparam logic [5:0] C  = 6'b001111;
    localparam logic [5:0] W  = 6'b000001;
    localparam logic [5:0] Z  = 6'b000000;
    localparam int EXIT_N  = 4;
    localparam int ENTRY_N = 3;
    localparam int SIREN_N = 8;
    localparam int TRIES   = 3;
    localparam int LOCK_N  = 5;

    localparam int M_OFF   = 0;
    localparam int M_EXIT  = 1;
    localparam int M_ARM   = 2;
    localparam int M_ENTRY = 3;
    localparam int M_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] code = '0;
    logic       code_valid = 1'b0;
    logic       motion1 = 1'b0;
    logic       motion2 = 1'b0;
    logic       reed = 1'b0;
    logic       armed;
    logic       entry_pending;
    logic       alarm;
    logic       lockout;

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_left;
    int m_fails;
    int m_lock;

    typedef struct {
        logic [5:0] c;
        logic       cv;
        logic       m1;
        logic       m2;
        logic       r;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    alarm_arm_controller #(
        .ARM_CODE   (C),
        .EXIT_DLY   (EXIT_N),
        .ENTRY_DLY  (ENTRY_N),
        .SIREN_TIME (SIREN_N),
        .MAX_TRIES  (TRIES),
        .LOCK_TIME  (LOCK_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .code          (code),
        .code_valid    (code_valid),
        .motion1       (motion1),
        .motion2       (motion2),
        .reed          (reed),
        .armed         (armed),
        .entry_pending (entry_pending),
        .alarm         (alarm),
        .lockout       (lockout)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {armed, entry_pending, alarm, lockout};
    endfunction

    function automatic logic [3:0] model_outs();
        logic a;
        a = (m_mode == M_ARM) || (m_mode == M_ENTRY) || (m_mode == M_ALARM);
        return {a, m_mode == M_ENTRY, m_mode == M_ALARM, m_lock > 0};
    endfunction

    function automatic void model_reset();
        m_mode  = M_OFF;
        m_left  = 0;
        m_fails = 0;
        m_lock  = 0;
    endfunction

    function automatic void go(input int mode, input int len);
        m_mode = mode;
        m_left = len;
    endfunction

    // m_left counts cycles still to spend in a timed state, including the current one.
    function automatic void model_step(input logic [5:0] c, input logic cv,
                                       input logic a, input logic b,
                                       input logic r);
        bit locked;
        bit ok;
        locked = (m_lock > 0);
        ok = cv && (c == C) && !locked;
`ifdef ALARM_LOCKOUT_EN
        if (m_lock > 0) m_lock--;
        if (ok) begin
            m_fails = 0;
        end else if (cv && !locked) begin
            m_fails++;
            if (m_fails == TRIES) begin
                m_fails = 0;
                m_lock  = LOCK_N;
            end
        end
`endif
        case (m_mode)
            M_OFF: if (ok) go(M_EXIT, EXIT_N);
            M_EXIT: begin
                if (ok) go(M_OFF, 0);
                else if (m_left == 1) go(M_ARM, 0);
                else m_left--;
            end
            M_ARM: begin
                if (ok) go(M_OFF, 0);
                else if (a || b) go(M_ALARM, SIREN_N);
                else if (r) go(M_ENTRY, ENTRY_N);
            end
            M_ENTRY: begin
                if (ok) go(M_OFF, 0);
                else if (m_left == 1) go(M_ALARM, SIREN_N);
                else m_left--;
            end
            default: begin
                if (ok) go(M_OFF, 0);
                else if (m_left == 1) go(M_ARM, 0);
                else m_left--;
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {armed,entry,alarm,lock}=%b expected %b",
                     name, act, exp);
        end
    endtask

    task automatic tick(input logic [5:0] c, input logic cv, input logic a,
                       input logic b, input logic r);
        code       = c;
        code_valid = cv;
        motion1    = a;
        motion2    = b;
        reed       = r;
        @(posedge clk);
        model_step(c, cv, a, b, r);
        #1;
        chk("model", outs(), model_outs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(Z, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tv(input logic [5:0] c, input logic cv, input logic a,
                      input logic b, input logic r, input logic [3:0] e);
        vec_t v;
        v.c = c; v.cv = cv; v.m1 = a; v.m2 = b; v.r = r; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();

        tv(W, 1, 0, 0, 0, 4'b0000);
        tv(C, 1, 0, 0, 0, 4'b0000);
        tv(Z, 0, 1, 0, 0, 4'b0000);
        tv(Z, 0, 0, 0, 1, 4'b0000);
        tv(Z, 0, 0, 1, 0, 4'b0000);
        tv(Z, 0, 0, 0, 0, 4'b1000);
        tv(Z, 0, 0, 0, 0, 4'b1000);
        tv(Z, 0, 0, 0, 1, 4'b1100);
        tv(Z, 0, 1, 0, 0, 4'b1100);
        tv(Z, 0, 0, 0, 0, 4'b1100);
        for (int i = 0; i < 8; i++) tv(Z, 0, 0, 0, 0, 4'b1010);
        tv(Z, 0, 0, 0, 0, 4'b1000);
        tv(Z, 0, 1, 0, 1, 4'b1010);
        tv(C, 1, 0, 0, 0, 4'b0000);
        tv(C, 1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 3; i++) tv(Z, 0, 0, 0, 0, 4'b0000);
        tv(Z, 0, 0, 0, 0, 4'b1000);
        tv(C, 1, 0, 1, 0, 4'b0000);
        tv(C, 1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 3; i++) tv(Z, 0, 0, 0, 0, 4'b0000);
        tv(Z, 0, 0, 0, 0, 4'b1000);
        tv(Z, 0, 0, 0, 1, 4'b1100);
        tv(C, 1, 0, 0, 0, 4'b0000);
        tv(C, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) tv(Z, 0, 0, 0, 0, 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].c, tbl[i].cv, tbl[i].m1, tbl[i].m2, tbl[i].r);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

`ifdef ALARM_LOCKOUT_EN
        tick(W, 1, 0, 0, 0); chk("lock_s1", outs(), 4'b0000);
        tick(W, 1, 0, 0, 0); chk("lock_s2", outs(), 4'b0000);
        tick(W, 1, 0, 0, 0); chk("lock_on", outs(), 4'b0001);
        tick(C, 1, 0, 0, 0); chk("lock_ign", outs(), 4'b0001);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk($sformatf("lock_hold%0d", i), outs(), 4'b0001);
        end
        idle(1); chk("lock_off", outs(), 4'b0000);
        idle(1); chk("lock_no_arm", outs(), 4'b0000);
        tick(C, 1, 0, 0, 0);
        idle(3); chk("lock_exit", outs(), 4'b0000);
        idle(1); chk("lock_armed", outs(), 4'b1000);
`else
        tick(W, 1, 0, 0, 0);
        tick(W, 1, 0, 0, 0);
        tick(W, 1, 0, 0, 0); chk("nolock_wrong", outs(), 4'b0000);
        tick(C, 1, 0, 0, 0);
        idle(3); chk("nolock_exit", outs(), 4'b0000);
        idle(1); chk("nolock_armed", outs(), 4'b1000);
`endif
        tick(C, 1, 0, 0, 0); chk("disarm", outs(), 4'b0000);

        tick(C, 1, 0, 0, 0);
        idle(EXIT_N);
        chk("pre_alarm_armed", outs(), 4'b1000);
        tick(Z, 0, 1, 0, 0);
        chk("pre_reset_alarm", outs(), 4'b1010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 4'b0000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(Z, 0, 1, 1, 1); chk("post_reset_sensors", outs(), 4'b0000);
        idle(EXIT_N + 1); chk("post_reset_idle", outs(), 4'b0000);

        for (int i = 0; i < 600; i++) begin
            logic [5:0] c;
            logic cv;
            cv = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 1) == 0) ? C : 6'($urandom_range(0, 63));
            tick(c, cv, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
